// File: rtl/aes128_rsm_ctrl_pkg.sv
// Shared constants for the AES-128 RSM sequencer: register word map, CTRL/STATUS
// bit positions, sequencer state encoding and the offset LFSR definition.
package aes128_rsm_ctrl_pkg;

  localparam logic [1:0] GRP_KEY = 2'd0;
  localparam logic [1:0] GRP_PT  = 2'd1;
  localparam logic [1:0] GRP_CT  = 2'd2;
  localparam logic [1:0] GRP_CSR = 2'd3;

  localparam logic [3:0] ADDR_CTRL   = 4'd12;
  localparam logic [3:0] ADDR_STATUS = 4'd13;
  localparam logic [3:0] ADDR_CYCLES = 4'd14;

  localparam int unsigned CTRL_START_BIT  = 0;
  localparam int unsigned CTRL_IRQ_EN_BIT = 1;
  localparam int unsigned CTRL_OFS_LSB    = 4;

  localparam int unsigned STAT_BUSY_BIT = 0;
  localparam int unsigned STAT_DONE_BIT = 1;
  localparam int unsigned STAT_TMO_BIT  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRE,
    ST_RUN,
    ST_DONE
  } seq_state_e;

  // x^4 + x^3 + 1, left-shifting Fibonacci form
  localparam logic [3:0] LFSR_TAPS = 4'b1100;
  localparam logic [3:0] LFSR_SEED = 4'b0001;

  function automatic logic [3:0] lfsr4_next(input logic [3:0] s);
    return {s[2:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/aes128_rsm_lfsr4.sv
// 4-bit mask-offset LFSR, advanced once per accepted start.
// Only built when RSM_OFFSET_LFSR_EN is defined.
`ifdef RSM_OFFSET_LFSR_EN
module aes128_rsm_lfsr4
  import aes128_rsm_ctrl_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  output logic [3:0] value_o
);

  logic [3:0] lfsr_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lfsr_q <= LFSR_SEED;
    end else if (en_i) begin
      lfsr_q <= lfsr4_next(lfsr_q);
    end
  end

  assign value_o = lfsr_q;

endmodule
`endif

// File: rtl/aes128_rsm_seq_ctrl.sv
// Sequencer between the register slave and the AES-128 RSM core: holds key/PT/CTRL,
// launches one encryption per start, captures CT/cycles. Option: RSM_OFFSET_LFSR_EN.
module aes128_rsm_seq_ctrl
  import aes128_rsm_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter int unsigned TRIG_PRE       = 2,
  parameter int unsigned CNT_W          = 16
) (
  input  logic         ACLK,
  input  logic         ARESET,
  input  logic         wr_en,
  input  logic [3:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic [3:0]   rd_addr,
  output logic [31:0]  rd_data,
  output logic [127:0] core_key,
  output logic [127:0] core_pt,
  output logic [3:0]   core_offset,
  output logic         core_start,
  input  logic         core_done,
  input  logic [127:0] core_ct,
  output logic         trigger,
  output logic         irq
);

  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  seq_state_e state_q, state_d;

  logic [31:0]      key_q [4];
  logic [31:0]      pt_q  [4];
  logic [31:0]      ct_q  [4];
  logic             irq_en_q;
  logic [3:0]       offset_q;
  logic             done_q;
  logic             tmo_q;
  logic [CNT_W-1:0] cycles_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       pre_cnt_q;
  logic             trigger_q;
  logic             core_start_q;
  logic [31:0]      rd_data_q;

  logic        busy;
  logic        ctrl_wr;
  logic        start_wr;
  logic        launch;
  logic        fire;
  logic        finish_ok;
  logic        finish_tmo;
  logic [31:0] rd_word;

  assign busy     = (state_q == ST_PRE) || (state_q == ST_RUN);
  assign ctrl_wr  = wr_en && (wr_addr == ADDR_CTRL);
  assign start_wr = ctrl_wr && wr_data[CTRL_START_BIT];

`ifdef RSM_OFFSET_LFSR_EN
  logic [3:0] lfsr_val;

  aes128_rsm_lfsr4 u_lfsr (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .en_i    (launch),
    .value_o (lfsr_val)
  );
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    launch     = 1'b0;
    fire       = 1'b0;
    finish_ok  = 1'b0;
    finish_tmo = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_wr) begin
          launch = 1'b1;
          if (TRIG_PRE == 0) begin
            state_d = ST_RUN;
            fire    = 1'b1;
          end else begin
            state_d = ST_PRE;
          end
        end
      end
      ST_PRE: begin
        if (pre_cnt_q <= 4'd1) begin
          state_d = ST_RUN;
          fire    = 1'b1;
        end
      end
      ST_RUN: begin
        if (core_done) begin
          finish_ok = 1'b1;
          state_d   = ST_DONE;
        end else if (cnt_q >= TMO_LAST) begin
          finish_tmo = 1'b1;
          state_d    = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_word = '0;
    case (rd_addr[3:2])
      GRP_KEY: rd_word = key_q[rd_addr[1:0]];
      GRP_PT:  rd_word = pt_q[rd_addr[1:0]];
      GRP_CT:  rd_word = ct_q[rd_addr[1:0]];
      default: begin
        case (rd_addr)
          ADDR_CTRL: begin
            rd_word[CTRL_IRQ_EN_BIT]       = irq_en_q;
            rd_word[CTRL_OFS_LSB +: 4]     = offset_q;
          end
          ADDR_STATUS: begin
            rd_word[STAT_BUSY_BIT] = busy;
            rd_word[STAT_DONE_BIT] = done_q;
            rd_word[STAT_TMO_BIT]  = tmo_q;
          end
          ADDR_CYCLES: rd_word = 32'(cycles_q);
          default:     rd_word = '0;
        endcase
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int unsigned i = 0; i < 4; i++) begin
        key_q[i] <= '0;
        pt_q[i]  <= '0;
        ct_q[i]  <= '0;
      end
      irq_en_q     <= 1'b0;
      offset_q     <= '0;
      done_q       <= 1'b0;
      tmo_q        <= 1'b0;
      cycles_q     <= '0;
      cnt_q        <= '0;
      pre_cnt_q    <= '0;
      trigger_q    <= 1'b0;
      core_start_q <= 1'b0;
      rd_data_q    <= '0;
    end else begin
      // Core inputs are frozen for the whole PRE/RUN window.
      if (wr_en && !busy && (wr_addr[3:2] == GRP_KEY)) key_q[wr_addr[1:0]] <= wr_data;
      if (wr_en && !busy && (wr_addr[3:2] == GRP_PT))  pt_q[wr_addr[1:0]]  <= wr_data;

      if (ctrl_wr) irq_en_q <= wr_data[CTRL_IRQ_EN_BIT];
`ifdef RSM_OFFSET_LFSR_EN
      if (launch) offset_q <= lfsr_val;
`else
      if (ctrl_wr && !busy) offset_q <= wr_data[CTRL_OFS_LSB +: 4];
`endif

      // Ordered so that a start clears and a finishing encryption sets over a SW clear.
      if (wr_en && (wr_addr == ADDR_STATUS)) begin
        if (wr_data[STAT_DONE_BIT]) done_q <= 1'b0;
        if (wr_data[STAT_TMO_BIT])  tmo_q  <= 1'b0;
      end
      if (launch) begin
        done_q <= 1'b0;
        tmo_q  <= 1'b0;
      end
      if (finish_ok || finish_tmo) done_q <= 1'b1;
      if (finish_tmo)              tmo_q  <= 1'b1;

      if (launch) begin
        pre_cnt_q <= 4'(TRIG_PRE);
      end else if (state_q == ST_PRE) begin
        pre_cnt_q <= pre_cnt_q - 4'd1;
      end

      core_start_q <= fire;

      if (fire) begin
        cnt_q <= '0;
      end else if (state_q == ST_RUN) begin
        cnt_q <= sat_inc(cnt_q);
      end

      if (launch) begin
        trigger_q <= 1'b1;
      end else if (finish_ok || finish_tmo) begin
        trigger_q <= 1'b0;
      end

      if (finish_ok) begin
        for (int unsigned i = 0; i < 4; i++) ct_q[i] <= core_ct[32*i +: 32];
        cycles_q <= sat_inc(cnt_q);
      end

      rd_data_q <= rd_word;
    end
  end

  assign rd_data     = rd_data_q;
  assign core_key    = {key_q[3], key_q[2], key_q[1], key_q[0]};
  assign core_pt     = {pt_q[3], pt_q[2], pt_q[1], pt_q[0]};
  assign core_offset = offset_q;
  assign core_start  = core_start_q;
  assign trigger     = trigger_q;
  assign irq         = done_q & irq_en_q;

endmodule

// File: doc/aes128_rsm_seq_ctrl.md
Name: aes128_rsm_seq_ctrl

Overview:
Sequencer between the AXI4-Lite register slave and the AES-128 RSM (rotating S-box masking) core. It holds key/plaintext/control words written by software, launches one masked encryption per start command, and captures the ciphertext and cycle count. It drives the scope trigger for side-channel capture and a timeout watchdog on the core. It sits inside the aes128_rsm_rtl IP, directly under the AXI slave register decode.

Parameters:
TIMEOUT_CYCLES, 64, max cycles from core_start to core_done before abort
TRIG_PRE, 2, cycles trigger rises before core_start pulse (0..15)
CNT_W, 16, width of encryption cycle counter

Ports:
ACLK  in  1  clock
ARESET  in  1  synchronous active-high reset
wr_en  in  1  register write strobe, one word per cycle
wr_addr  in  4  word address of write
wr_data  in  32  write data
rd_addr  in  4  word address of read
rd_data  out  32  read data, registered, valid 1 cycle after rd_addr
core_key  out  128  key to core, stable while busy
core_pt  out  128  plaintext to core, stable while busy
core_offset  out  4  RSM mask offset, stable while busy
core_start  out  1  single-cycle launch pulse
core_done  in  1  single-cycle completion pulse
core_ct  in  128  ciphertext, valid with core_done
trigger  out  1  scope trigger
irq  out  1  level, high while STATUS.done set and CTRL.irq_en set

Behaviour:
- Interface: one clock ACLK; reset ARESET is synchronous and active-high.
- Word map: 0-3 KEY[31:0..127:96], 4-7 PT (same order), 8-11 CT (RO), 12 CTRL, 13 STATUS, 14 CYCLES (RO, zero-extended).
- CTRL: bit0 start (write-1, self-clearing, reads 0), bit1 irq_en, bits 7:4 offset. STATUS: bit0 busy, bit1 done (sticky), bit2 timeout (sticky); write 1 to bit1/bit2 clears them.
- Reset: all outputs 0, all registers 0, FSM IDLE.
- FSM states IDLE, PRE, RUN, DONE.
- IDLE: write with CTRL.start=1 -> PRE, busy=1, done/timeout cleared, trigger=1, pre-counter loaded with TRIG_PRE. If TRIG_PRE=0, go straight to RUN with core_start the next cycle.
- PRE: decrement each cycle; on reaching 0 -> RUN, core_start=1 for exactly one cycle, cycle counter cleared.
- RUN: counter increments each cycle, saturating at all-ones. On core_done: CT <= core_ct, CYCLES <= counter+1, trigger=0 -> DONE. If counter reaches TIMEOUT_CYCLES first: timeout=1, trigger=0, CT unchanged -> DONE.
- DONE: one cycle; busy=0, done=1 (also on timeout) -> IDLE.
- Writes to KEY/PT/CTRL.offset while busy are ignored (core inputs stay stable). Start while busy is ignored.
- core_done in IDLE/PRE/DONE is ignored.
- Write to STATUS clear in the same cycle the FSM sets done: set wins.
- Simultaneous read and write of the same word: rd_data returns the old value.
- ARESET mid-RUN: immediate return to IDLE, all outputs 0. The core is reset by the same ARESET.

Optional Feature:
RSM_OFFSET_LFSR_EN
- Defined: a 4-bit internal LFSR (x^4+x^3+1, seed 4'b0001 at reset) advances once per start. core_offset takes the LFSR value, CTRL[7:4] is ignored on write, and CTRL[7:4] reads back the offset used.
- Undefined: core_offset = CTRL[7:4] as written.

Decomposition:
- Package aes128_rsm_ctrl_pkg: word-address localparams, CTRL/STATUS bit indices, FSM state enum, LFSR taps/seed.
- Sub-module aes128_rsm_lfsr4 (enable, output), instantiated only under the macro.

Test Plan:
- FIPS-197 C.1 vector: key 000102..0f, PT 00112233..ff, offset 3, start, with a core model that returns the known CT 69c4e0d8..c55a after 11 cycles -> words 8-11 = 0x69c4e0d8.., CYCLES=11, done=1, trigger high TRIG_PRE+11 cycles.
- Core model never asserts done -> timeout=1 and done=1 after 64 cycles, CT stays 0, busy=0.
- Write KEY word 0 = 0xDEADBEEF and a second start while busy -> core_key unchanged, a single core_start pulse observed.
- irq_en=1, encryption completes -> irq=1; write STATUS=0x2 -> irq=0 the next cycle.
- ARESET asserted mid-RUN -> the next cycle all outputs are 0 and STATUS reads 0; a new start runs normally.
- With RSM_OFFSET_LFSR_EN: three starts -> core_offset sequence 0x1, 0x2, 0x4 (per the taps), CTRL[7:4] reads each value.
